// File: rtl/ireq_arb_pkg.sv
// Shared types and constants for the ireq arbiter slice.
package ireq_arb_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StXfer  = 2'd1,
    StDrain = 2'd2
  } state_e;

  // SRIO FTYPE field values carried in the header tuser
  localparam logic [3:0] FTYPE_DOORB = 4'hA;
  localparam logic [3:0] FTYPE_NWR   = 4'h5;

  // 1 header beat + 32 data beats = 256 payload bytes
  localparam int unsigned DEF_MAX_BEATS = 33;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned KEEP_W = 8;
  localparam int unsigned USER_W = 32;

endpackage

// File: rtl/ireq_arb_if.sv
// AXI-Stream ireq bundle, LANES streams packed side by side (lane i = slice i).
interface ireq_arb_if
  import ireq_arb_pkg::*;
#(
  parameter int unsigned LANES = 1
);

  logic [LANES-1:0]        tvalid;
  logic [LANES-1:0]        tready;
  logic [LANES-1:0]        tlast;
  logic [LANES*DATA_W-1:0] tdata;
  logic [LANES*KEEP_W-1:0] tkeep;
  logic [LANES*USER_W-1:0] tuser;

  modport master (output tvalid, tdata, tkeep, tlast, tuser, input tready);
  modport slave  (input tvalid, tdata, tkeep, tlast, tuser, output tready);

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin search starting one past the last winner.
module rr_pick #(
  parameter int unsigned NUM_REQ = 3
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [1:0]         last,
  output logic [NUM_REQ-1:0] gnt,
  output logic [1:0]         idx
);

  logic [1:0] cand;

  // First requester found in the order last+1, last+2, ... wins
  always_comb begin
    gnt  = '0;
    idx  = '0;
    cand = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = 2'((32'(last) + k) % NUM_REQ);
      if (gnt == '0 && req[cand]) begin
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/ireq_arb.sv
// Packet-level round-robin merge of NUM_REQ ireq streams onto one SRIO ireq port.
module ireq_arb
  import ireq_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 3,
  parameter int unsigned MAX_BEATS = DEF_MAX_BEATS
) (
  input  logic               log_clk,
  input  logic               log_rst,
  ireq_arb_if.slave          s,
  ireq_arb_if.master         m,
  output logic [NUM_REQ-1:0] grant_o,
  output logic               busy_o,
  output logic               err_len_o,
  output logic [1:0]         err_src_o
);

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [1:0]         gidx_q, gidx_d;
  logic [1:0]         last_q, last_d;
  logic [5:0]         beat_q, beat_d;
  logic               err_len_q, err_len_d;
  logic [1:0]         err_src_q, err_src_d;

  logic [NUM_REQ-1:0] pick_gnt;
  logic [1:0]         pick_idx;
  logic               at_max;
  logic               beat_acc;

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .req  (s.tvalid),
    .last (last_q),
    .gnt  (pick_gnt),
    .idx  (pick_idx)
  );

  assign at_max   = (beat_q == 6'(MAX_BEATS - 1));
  assign beat_acc = m.tvalid[0] & m.tready[0];

  // State register; reset aborts any packet in flight and favours requester 0 next
  always_ff @(posedge log_clk or posedge log_rst) begin
    if (log_rst) begin
      state_q   <= StIdle;
      grant_q   <= '0;
      gidx_q    <= '0;
      last_q    <= 2'(NUM_REQ - 1);
      beat_q    <= '0;
      err_len_q <= 1'b0;
      err_src_q <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      gidx_q    <= gidx_d;
      last_q    <= last_d;
      beat_q    <= beat_d;
      err_len_q <= err_len_d;
      err_src_q <= err_src_d;
    end
  end

  // Next-state: arbitrate in idle, hold the grant until tlast (real or forced)
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    gidx_d    = gidx_q;
    last_d    = last_q;
    beat_d    = beat_q;
    err_len_d = 1'b0;
    err_src_d = err_src_q;
    unique case (state_q)
      StIdle: begin
        beat_d = '0;
        if (|s.tvalid) begin
          grant_d = pick_gnt;
          gidx_d  = pick_idx;
          state_d = StXfer;
        end
      end
      StXfer: begin
        if (beat_acc) begin
          beat_d = beat_q + 6'd1;
          if (s.tlast[gidx_q]) begin
            state_d = StIdle;
            last_d  = gidx_q;
            grant_d = '0;
            beat_d  = '0;
          end else if (at_max) begin
            // Oversize: downstream already saw a forced tlast; swallow the rest
            err_len_d = 1'b1;
            err_src_d = gidx_q;
            state_d   = StDrain;
          end
        end
      end
      StDrain: begin
        if (s.tvalid[gidx_q] && s.tlast[gidx_q]) begin
          state_d = StIdle;
          last_d  = gidx_q;
          grant_d = '0;
          beat_d  = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Datapath mux of the granted slice; everything quiet outside XFER
  always_comb begin
    s.tready = '0;
    m.tvalid = '0;
    m.tlast  = '0;
    m.tdata  = '0;
    m.tkeep  = '0;
    m.tuser  = '0;
    if (state_q == StXfer) begin
      m.tvalid[0]      = s.tvalid[gidx_q];
      m.tlast[0]       = s.tlast[gidx_q] | at_max;
      m.tdata          = s.tdata[{gidx_q, 6'd0} +: 64];
      m.tkeep          = s.tkeep[{gidx_q, 3'd0} +: 8];
      m.tuser          = s.tuser[{gidx_q, 5'd0} +: 32];
      s.tready[gidx_q] = m.tready[0];
    end else if (state_q == StDrain) begin
      s.tready[gidx_q] = 1'b1;
    end
  end

  assign grant_o   = grant_q;
  assign busy_o    = (state_q != StIdle);
  assign err_len_o = err_len_q;
  assign err_src_o = err_src_q;

endmodule

// File: tb/tb_ireq_arb.sv
// Directed bench for ireq_arb: per-requester source queues feed the DUT, a
// scoreboard of expected merged beats is popped as the DUT emits them.
module tb_ireq_arb;
  import ireq_arb_pkg::*;

  localparam int unsigned NR = 3;
  localparam int unsigned MB = 33;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic [31:0] user;
  } beat_t;

  logic          log_clk = 1'b0;
  logic          log_rst = 1'b1;
  logic [NR-1:0] grant;
  logic          busy;
  logic          err_len;
  logic [1:0]    err_src;

  ireq_arb_if #(.LANES(NR)) s_if ();
  ireq_arb_if #(.LANES(1))  m_if ();

  ireq_arb #(
    .NUM_REQ   (NR),
    .MAX_BEATS (MB)
  ) dut (
    .log_clk   (log_clk),
    .log_rst   (log_rst),
    .s         (s_if),
    .m         (m_if),
    .grant_o   (grant),
    .busy_o    (busy),
    .err_len_o (err_len),
    .err_src_o (err_src)
  );

  always #5 log_clk = ~log_clk;

  beat_t         src_q [NR][$];
  beat_t         exp_q [$];
  logic [NR-1:0] fire = '0;
  int            n_chk = 0;
  int            n_pass = 0;
  int            n_acc = 0;
  int            n_err = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic beat_t mk(input int r, input int p, input int k, input int n,
                               input logic [3:0] ft);
    beat_t b;
    b.data = {8'(r), 8'(p), 16'(k), 32'hC0DE_0000 | 32'(k)};
    b.keep = (k == n) ? 8'h0F : 8'hFF;
    b.last = (k == n);
    b.user = (k == 1) ? {4'(r), 16'h0, 8'(p), ft} : 32'(k);
    return b;
  endfunction

  // Queue n source beats for requester r; the first n_exp appear downstream,
  // with tlast forced on beat MB if the packet is longer
  task automatic send(input int r, input int p, input int n, input int n_exp,
                      input logic [3:0] ft);
    beat_t b;
    for (int k = 1; k <= n; k++) begin
      b = mk(r, p, k, n, ft);
      src_q[r].push_back(b);
      if (k <= n_exp) begin
        b.last = (k == n) || (k == MB);
        exp_q.push_back(b);
      end
    end
  endtask

  function automatic logic src_empty();
    logic e = 1'b1;
    for (int i = 0; i < NR; i++) if (src_q[i].size() != 0) e = 1'b0;
    return e;
  endfunction

  task automatic wait_idle(input string tag);
    logic ok = 1'b0;
    for (int t = 0; t < 400 && !ok; t++) begin
      @(negedge log_clk); #1;
      ok = !busy && exp_q.size() == 0 && src_empty();
    end
    chk({"done_", tag}, 128'(ok), 128'(1'b1));
  endtask

  // Requester drivers: retire beats seen handshaking, present the next head
  initial begin
    beat_t h;
    s_if.tvalid = '0;
    s_if.tlast  = '0;
    s_if.tdata  = '0;
    s_if.tkeep  = '0;
    s_if.tuser  = '0;
    forever begin
      @(posedge log_clk); #1;
      for (int i = 0; i < NR; i++) begin
        if (fire[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        if (src_q[i].size() > 0) begin
          h = src_q[i][0];
          s_if.tvalid[i]          = 1'b1;
          s_if.tlast[i]           = h.last;
          s_if.tdata[i*64 +: 64]  = h.data;
          s_if.tkeep[i*8 +: 8]    = h.keep;
          s_if.tuser[i*32 +: 32]  = h.user;
        end else begin
          s_if.tvalid[i]          = 1'b0;
          s_if.tlast[i]           = 1'b0;
          s_if.tdata[i*64 +: 64]  = '0;
          s_if.tkeep[i*8 +: 8]    = '0;
          s_if.tuser[i*32 +: 32]  = '0;
        end
      end
      fire = '0;
    end
  end

  // Output monitor: every accepted merged beat must match the scoreboard head
  initial begin
    beat_t e;
    forever begin
      @(negedge log_clk);
      fire = s_if.tvalid & s_if.tready;
      if (err_len) n_err++;
      if (m_if.tvalid[0] && m_if.tready[0]) begin
        n_acc++;
        if (exp_q.size() == 0) begin
          n_chk++;
          $error("FAIL unexpected_beat: observed %0h expected no beat", m_if.tdata);
        end else begin
          e = exp_q.pop_front();
          chk("beat", 128'({m_if.tdata, m_if.tkeep, m_if.tlast[0], m_if.tuser}), 128'(e));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   base;
    int   e0;
    logic tog;
    logic seen;
    m_if.tready = 1'b1;
    log_rst     = 1'b1;

    // Reset values
    @(negedge log_clk); #1;
    chk("rst_grant", 128'(grant), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_sready", 128'(s_if.tready), 128'(0));
    chk("rst_m", 128'({m_if.tvalid, m_if.tlast, m_if.tdata, m_if.tkeep, m_if.tuser}), 128'(0));
    chk("rst_err", 128'({err_len, err_src}), 128'(0));
    log_rst = 1'b0;
    @(negedge log_clk); #1;

    // Contention: all three hold a 2-beat packet, order must be 0,1,2
    send(0, 1, 2, 2, FTYPE_NWR);
    send(1, 1, 2, 2, FTYPE_NWR);
    send(2, 1, 2, 2, FTYPE_NWR);
    @(negedge log_clk); #1;
    chk("cont_grant_lat", 128'(grant), 128'(0));
    @(negedge log_clk); #1;
    chk("cont_grant0", 128'(grant), 128'(3'b001));
    wait_idle("contention");

    // Single requester, 3 beats
    send(1, 2, 3, 3, FTYPE_NWR);
    @(negedge log_clk); #1;
    chk("single_grant_lat", 128'(grant), 128'(0));
    @(negedge log_clk); #1;
    chk("single_grant", 128'(grant), 128'(3'b010));
    chk("single_busy", 128'(busy), 128'(1));
    wait_idle("single");
    chk("single_grant_clr", 128'(grant), 128'(0));

    // Backpressure 1010 on a 4-beat packet from req0
    base = n_acc;
    send(0, 3, 4, 4, FTYPE_NWR);
    tog  = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge log_clk); #1;
      m_if.tready = tog;
      tog = ~tog;
      @(negedge log_clk); #1;
      if (busy) begin
        seen = 1'b1;
        chk("tready_mirror", 128'(s_if.tready), 128'(m_if.tready[0] ? 3'b001 : 3'b000));
      end else if (seen) begin
        break;
      end
    end
    m_if.tready = 1'b1;
    wait_idle("backpressure");
    chk("bp_beats", 128'(n_acc - base), 128'(4));

    // Oversize: 40 beats from req2, 33 pass with forced tlast, rest drained
    base = n_acc;
    e0   = n_err;
    send(2, 4, 40, MB, FTYPE_NWR);
    wait_idle("oversize");
    chk("ovr_beats", 128'(n_acc - base), 128'(MB));
    chk("ovr_err_pulses", 128'(n_err - e0), 128'(1));
    chk("ovr_err_src", 128'(err_src), 128'(2));

    // Single-beat packet; error source must still be held
    base = n_acc;
    send(0, 5, 1, 1, FTYPE_DOORB);
    wait_idle("one_beat");
    chk("one_beat_cnt", 128'(n_acc - base), 128'(1));
    chk("err_src_hold", 128'(err_src), 128'(2));

    // Reset during beat 2 of a 5-beat packet from req1
    base = n_acc;
    send(1, 6, 5, 2, FTYPE_NWR);
    for (int c = 0; c < 50; c++) begin
      @(negedge log_clk); #1;
      if (n_acc - base >= 2) break;
    end
    @(posedge log_clk); #1;
    log_rst = 1'b1;
    src_q[1].delete();
    @(negedge log_clk); #1;
    chk("mid_rst_tvalid", 128'(m_if.tvalid), 128'(0));
    chk("mid_rst_grant", 128'(grant), 128'(0));
    chk("mid_rst_busy", 128'(busy), 128'(0));
    chk("mid_rst_sready", 128'(s_if.tready), 128'(0));
    chk("mid_rst_err_src", 128'(err_src), 128'(0));
    send(0, 7, 2, 2, FTYPE_NWR);
    send(2, 7, 2, 2, FTYPE_NWR);
    @(negedge log_clk); #1;
    chk("mid_rst_tvalid2", 128'(m_if.tvalid), 128'(0));
    chk("mid_rst_beats", 128'(n_acc - base), 128'(2));
    log_rst = 1'b0;
    @(negedge log_clk); #1;
    chk("post_rst_grant", 128'(grant), 128'(3'b001));
    wait_idle("post_reset");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ireq_arb.md
IREQ_ARB -- requirements
Module: ireq_arb

Interface
REQ-001 SHALL have parameter NUM_REQ, default 3: number of ireq requesters (2..4).
REQ-002 SHALL have parameter MAX_BEATS, default 33: max beats per packet (1 header + 32 data beats = 256 bytes).
REQ-003 SHALL have input log_clk, 1 bit: clock; all logic rises on log_clk.
REQ-004 SHALL have input log_rst, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have inputs s_tvalid, s_tlast (NUM_REQ bits), s_tdata (NUM_REQ*64), s_tkeep (NUM_REQ*8), s_tuser (NUM_REQ*32): per-requester ireq AXI-Stream; slice i = requester i.
REQ-006 SHALL have output s_tready, NUM_REQ bits: per-requester ready.
REQ-007 SHALL have outputs m_ireq_tvalid (1), m_ireq_tdata (64), m_ireq_tkeep (8), m_ireq_tlast (1), m_ireq_tuser (32), and input m_ireq_tready (1): merged ireq to the SRIO core.
REQ-008 SHALL have output grant_o, NUM_REQ bits: one-hot current owner, all zero when idle.
REQ-009 SHALL have output busy_o, 1 bit: high in XFER or DRAIN.
REQ-010 SHALL have outputs err_len_o (1-cycle pulse) and err_src_o (2 bits): truncation error and offending requester index.

Function
REQ-011 SHALL implement FSM states IDLE, XFER, DRAIN.
REQ-012 IDLE: when any s_tvalid is high, SHALL select a requester round-robin, searching from last_grant+1 modulo NUM_REQ, register the one-hot grant, and go to XFER next cycle (1-cycle arbitration latency).
REQ-013 IDLE: s_tready SHALL be all zero and m_ireq_tvalid SHALL be 0.
REQ-014 XFER: m_ireq_tvalid/tdata/tkeep/tuser SHALL be a combinational mux of the granted slice; s_tready[g] = m_ireq_tready; other s_tready bits 0.
REQ-015 A beat is accepted when m_ireq_tvalid and m_ireq_tready are both high; beat_cnt (6 bits) SHALL increment per accepted beat and clear on entering IDLE.
REQ-016 XFER: m_ireq_tlast = s_tlast[g] OR (beat_cnt == MAX_BEATS-1).
REQ-017 On an accepted beat with s_tlast[g] high: SHALL go to IDLE, set last_grant = g, and clear grant_o on the next cycle.
REQ-018 On an accepted beat with beat_cnt == MAX_BEATS-1 and s_tlast[g] low: SHALL pulse err_len_o for 1 cycle, set err_src_o = g, and go to DRAIN.
REQ-019 DRAIN: m_ireq_tvalid SHALL be 0 and s_tready[g] SHALL be 1; on s_tvalid[g] and s_tlast[g] both high, SHALL go to IDLE with last_grant = g.
REQ-020 Grant SHALL never change mid-packet; tvalid deassertion by the owner mid-packet SHALL hold XFER indefinitely (no timeout).
REQ-021 Simultaneous requests SHALL be resolved only by round-robin order; a requester SHALL wait at most NUM_REQ-1 packets.
REQ-022 A single-beat packet (tlast on the header) SHALL be accepted; IDLE to IDLE turnaround is 2 cycles minimum.
REQ-023 err_src_o SHALL hold its value until the next error.

Reset
REQ-024 While log_rst is high: state = IDLE, grant_o = 0, last_grant = NUM_REQ-1, beat_cnt = 0, s_tready = 0, m_ireq_tvalid = 0, m_ireq_tlast = 0, m_ireq_tdata/tkeep/tuser = 0, busy_o = 0, err_len_o = 0, err_src_o = 0.
REQ-025 Reset asserted mid-packet SHALL abort the packet immediately with no further beats; after release, arbitration restarts with requester 0 favoured.

Structure
REQ-026 Shared package SHALL hold: FSM state encoding, FTYPE constants (DOORB = 4'hA, NWR = 4'h5), and the default MAX_BEATS.
REQ-027 A sub-module rr_pick (NUM_REQ request vector plus last index in; one-hot grant plus index out, purely combinational) SHALL implement the round-robin search.

Verification
REQ-028 Single requester: req1 sends a 3-beat packet with tready=1 -> grant_o=3'b010 one cycle after tvalid; m_ireq output shows 3 beats with tlast on beat 3; busy_o falls after tlast.
REQ-029 Contention: req0, req1 and req2 each hold a 2-beat packet from cycle 0 -> packet order 0,1,2; no interleaving of beats.
REQ-030 Backpressure: m_ireq_tready toggles 1010 during a 4-beat packet -> exactly 4 beats accepted, and s_tready[g] mirrors m_ireq_tready.
REQ-031 Oversize: req2 sends 40 beats with no tlast until beat 40 -> beat 33 is output with tlast=1; err_len_o pulses with err_src_o=2; beats 34..40 are consumed with no output; then IDLE.
REQ-032 Reset at beat 2 of a 5-beat packet -> m_ireq_tvalid=0 while reset is high; after release, req0 wins the first arbitration when req0 and req2 are both pending.
